// File: rtl/calc_entry_fsm.sv
// Four-function 8-bit calculator entry controller: debounced enter/clear
// buttons step through operand A, operand B, operation and result states.
module calc_entry_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw,
    input  logic [1:0]  op_sel,
    input  logic        btn_enter,
    input  logic        btn_clear,
    output logic [15:0] disp_value,
    output logic        neg,
    output logic [1:0]  state
);

    localparam int unsigned NBTN = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    // Button index 0 is enter, index 1 is clear.
    logic [NBTN-1:0]            sync1, sync2, acc, acc_q;
    logic [NBTN-1:0][CNT_W-1:0] cnt;
    logic [NBTN-1:0]            press_c;

    state_t      state_q, state_n;
    logic [7:0]  a_q, a_n, b_q, b_n;
    logic [15:0] res_q, res_n, disp_n;
    logic        neg_n;
    logic        enter_c, clear_c;

    // Synchronize raw buttons, then debounce: a level is accepted only after
    // it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {btn_clear, btn_enter};
            sync2 <= sync1;
            acc_q <= acc;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == acc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    acc[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press pulse on the rising edge of each accepted level.
    assign press_c = acc & ~acc_q;
    assign enter_c = press_c[0];
    assign clear_c = press_c[1];

    // State, operand, result and display registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            neg        <= 1'b0;
            disp_value <= '0;
        end else begin
            state_q    <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            res_q      <= res_n;
            neg        <= neg_n;
            disp_value <= disp_n;
        end
    end

    assign state = state_q;

    // Next-state, operand latching, result computation and display select.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        res_n   = res_q;
        neg_n   = neg;

        if (clear_c) begin
            state_n = S_A;
            a_n     = '0;
            b_n     = '0;
            res_n   = '0;
            neg_n   = 1'b0;
        end else if (enter_c) begin
            case (state_q)
                S_A: begin
                    a_n     = sw;
                    state_n = S_B;
                end
                S_B: begin
                    b_n     = sw;
                    state_n = S_OP;
                end
                S_OP: begin
                    state_n = S_RES;
                    neg_n   = 1'b0;
                    case (op_sel)
                        2'b00: res_n = 16'(a_q) + 16'(b_q);
                        2'b01: begin
                            if (a_q >= b_q) begin
                                res_n = 16'(a_q - b_q);
                            end else begin
                                res_n = 16'(b_q - a_q);
                                neg_n = 1'b1;
                            end
                        end
                        2'b10: res_n = 16'(a_q) * 16'(b_q);
                        default: res_n = {8'h00, a_q & b_q};
                    endcase
                end
                default: begin
                    state_n = S_A;
                    neg_n   = 1'b0;
                end
            endcase
        end

        case (state_q)
            S_OP:    disp_n = {a_q, b_q};
            S_RES:   disp_n = res_q;
            default: disp_n = {8'h00, sw};
        endcase
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scenario bench for calc_entry_fsm with a short debounce period.
module tb_calc_entry_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sw;
    logic [1:0]  op_sel;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] disp_value;
    logic        neg;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Expected {state, neg, disp_value}, pushed at stimulus, popped at check.
    logic [18:0] exp_q[$];
    logic [18:0] e;

    calc_entry_fsm #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .op_sel     (op_sel),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .disp_value (disp_value),
        .neg        (neg),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic en, input logic cl);
        btn_enter = en;
        btn_clear = cl;
        cyc(12);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cyc(12);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sw = 8'hA5;
        exp_q.push_back({2'b00, 1'b0, 16'h0000});
        cyc(3);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL reset_hold: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        rst_n = 1'b1;
        exp_q.push_back({2'b00, 1'b0, 16'h00A5});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL reset_release: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_glitch;
        int trans = 0;
        logic [1:0] prev;
        sw = 8'h3C;
        prev = state;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) begin
                btn_enter = (k < 2);
                cyc(1);
                if (state !== prev) trans++;
                prev = state;
            end
        end
        total++;
        if (state !== 2'b00) begin bad++;
            $display("FAIL glitch_no_accept: got st=%b want st=00", state); end
        for (int k = 0; k < 32; k++) begin
            btn_enter = (k < 20);
            cyc(1);
            if (state !== prev) trans++;
            prev = state;
        end
        total++;
        if (trans !== 1) begin bad++;
            $display("FAIL glitch_one_pulse: got transitions=%0d want 1", trans); end
        exp_q.push_back({2'b01, 1'b0, 16'h003C});
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL glitch_state: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_clear;
        exp_q.push_back({2'b00, 1'b0, 16'h003C});
        press(1'b0, 1'b1);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL clear: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_mul;
        sw = 8'hFF; op_sel = 2'b00;
        exp_q.push_back({2'b01, 1'b0, 16'h00FF});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mul_a: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        exp_q.push_back({2'b10, 1'b0, 16'hFFFF});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mul_op: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        op_sel = 2'b10;
        exp_q.push_back({2'b11, 1'b0, 16'hFE01});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mul_res: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        op_sel = 2'b00; sw = 8'h00;
        exp_q.push_back({2'b11, 1'b0, 16'hFE01});
        cyc(5);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mul_opsel_hold: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        exp_q.push_back({2'b00, 1'b0, 16'h0000});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mul_wrap: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_sub;
        sw = 8'h03;
        press(1'b1, 1'b0);
        sw = 8'h10;
        press(1'b1, 1'b0);
        op_sel = 2'b01;
        exp_q.push_back({2'b11, 1'b1, 16'h000D});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL sub_res: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        exp_q.push_back({2'b00, 1'b0, 16'h0010});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL sub_wrap: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_add_clear_priority;
        sw = 8'hFF;
        press(1'b1, 1'b0);
        sw = 8'h01;
        press(1'b1, 1'b0);
        op_sel = 2'b00;
        exp_q.push_back({2'b11, 1'b0, 16'h0100});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL add_res: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        sw = 8'h77;
        exp_q.push_back({2'b00, 1'b0, 16'h0077});
        press(1'b1, 1'b1);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL enter_clear_same: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
    endtask

    task automatic test_reset_mid;
        sw = 8'h12;
        press(1'b1, 1'b0);
        sw = 8'h34;
        exp_q.push_back({2'b10, 1'b0, 16'h1234});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mid_op: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        rst_n = 1'b0;
        exp_q.push_back({2'b00, 1'b0, 16'h0000});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mid_reset: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        rst_n = 1'b1;
        sw = 8'h56;
        press(1'b1, 1'b0);
        sw = 8'h78;
        exp_q.push_back({2'b10, 1'b0, 16'h5678});
        press(1'b1, 1'b0);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL mid_restart: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        press(1'b0, 1'b1);
    endtask

    task automatic test_held_through_reset;
        sw = 8'h9A;
        btn_enter = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        exp_q.push_back({2'b00, 1'b0, 16'h009A});
        cyc(5);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL held_early: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        exp_q.push_back({2'b01, 1'b0, 16'h009A});
        cyc(5);
        e = exp_q.pop_front(); total++;
        if ({state, neg, disp_value} !== e) begin bad++;
            $display("FAIL held_pulse: got st=%b neg=%b disp=%h want st=%b neg=%b disp=%h", state, neg, disp_value, e[18:17], e[16], e[15:0]); end
        btn_enter = 1'b0;
        cyc(12);
    endtask

    initial begin
        rst_n = 1'b0; sw = '0; op_sel = '0; btn_enter = 1'b0; btn_clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_glitch();
        test_clear();
        test_mul();
        test_sub();
        test_add_clear_priority();
        test_reset_mid();
        test_held_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
